// File: rtl/spi_burst_pkg.sv
// Shared types and width helpers for the buffered SPI burst transmitter.
package spi_burst_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    function automatic int cs_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold values 0..n-1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_burst_tx_if.sv
// Write port, burst control and SPI pins of spi_burst_tx bundled as one interface.
interface spi_burst_tx_if
    import spi_burst_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int NUM_CS = 1
) ();
    localparam int CS_W = cs_w(NUM_CS);

    logic [DATA_W-1:0]       din;
    logic                    din_valid;
    logic                    din_ready;
    logic [$clog2(DEPTH):0]  level;
    logic                    start;
    logic [CS_W-1:0]         cs_sel;
    logic                    cpol;
    logic                    busy;
    logic                    done;
    logic                    spi_clk;
    logic                    spi_mosi;
    logic [NUM_CS-1:0]       cs_n;

    modport master (
        output din, din_valid, start, cs_sel, cpol,
        input  din_ready, level, busy, done, spi_clk, spi_mosi, cs_n
    );

    modport slave (
        input  din, din_valid, start, cs_sel, cpol,
        output din_ready, level, busy, done, spi_clk, spi_mosi, cs_n
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read and registered occupancy.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_W-1:0]      wdata,
    output logic [DATA_W-1:0]      rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    assign rdata = mem[rd_ptr];
    assign full  = (level == (AW+1)'(DEPTH));

    // Pointers are exactly AW bits wide so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/spi_burst_tx.sv
// SPI master (CPHA=0) that drains its FIFO as one chip-select-framed burst per start.
module spi_burst_tx
    import spi_burst_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 32,
    parameter int CLK_DIV = 4,
    parameter int NUM_CS  = 1
) (
    input logic            clk,
    input logic            rst,
    spi_burst_tx_if.slave  bus
);
    localparam int CS_W = cs_w(NUM_CS);
    localparam int LW   = $clog2(DEPTH) + 1;
    localparam int DW   = cnt_w(CLK_DIV);
    localparam int BW   = cnt_w(DATA_W);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    state_t            state;
    logic [DW-1:0]     div_cnt;
    logic [BW-1:0]     bit_cnt;
    logic              trail;
    logic              more;
    logic              cpol_q;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] head;
    logic [LW-1:0]     level;
    logic              full;
    logic              push;
    logic              pop;
    logic              start_ok;
    logic              half_end;
    logic              last_bit;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (bus.din),
        .rdata (head),
        .level (level),
        .full  (full)
    );

    assign bus.din_ready = !full && !rst;
    assign bus.level     = level;
    assign push     = bus.din_valid && bus.din_ready;
    assign start_ok = (state == IDLE) && bus.start && (level != '0);
    assign half_end = (div_cnt == DIV_LAST);
    assign last_bit = (bit_cnt == BIT_LAST);
    // The next word is fetched at the trailing edge of the last bit so its MSB gets a full half-period of setup.
    assign pop = start_ok ||
                 ((state == SHIFT) && half_end && !trail && last_bit && (level != '0));

    // Out-of-range selects leave every line deasserted.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] m;
        m = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (sel == CS_W'(i)) m[i] = 1'b0;
        end
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (pop)
            shreg <= head;
        else if ((state == SHIFT) && half_end && !trail)
            shreg <= shreg << 1;
        if (start_ok) cpol_q <= bus.cpol;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            trail        <= 1'b0;
            more         <= 1'b0;
            bus.spi_clk  <= 1'b0;
            bus.spi_mosi <= 1'b0;
            bus.cs_n     <= '1;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    bus.spi_clk <= bus.cpol;
                    div_cnt     <= '0;
                    if (start_ok) begin
                        state        <= SETUP;
                        bus.cs_n     <= cs_decode(bus.cs_sel);
                        bus.spi_mosi <= head[DATA_W-1];
                        bus.busy     <= 1'b1;
                    end
                end
                SETUP: begin
                    if (half_end) begin
                        div_cnt     <= '0;
                        bit_cnt     <= '0;
                        trail       <= 1'b0;
                        state       <= SHIFT;
                        bus.spi_clk <= !cpol_q;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (!half_end) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        trail   <= !trail;
                        if (!trail) begin
                            bus.spi_clk <= cpol_q;
                            if (!last_bit) begin
                                bus.spi_mosi <= shreg[DATA_W-2];
                            end else begin
                                more <= (level != '0);
                                if (level != '0) bus.spi_mosi <= head[DATA_W-1];
                            end
                        end else if (!last_bit) begin
                            bit_cnt     <= bit_cnt + 1'b1;
                            bus.spi_clk <= !cpol_q;
                        end else if (more) begin
                            bit_cnt     <= '0;
                            bus.spi_clk <= !cpol_q;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!half_end) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt      <= '0;
                        state        <= IDLE;
                        bus.cs_n     <= '1;
                        bus.done     <= 1'b1;
                        bus.busy     <= 1'b0;
                        bus.spi_mosi <= 1'b0;
                        bus.spi_clk  <= bus.cpol;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_burst_tx.sv
// Directed and randomized bursts checked against a queue-based model of the SPI wire behaviour.
module tb_spi_burst_tx;
    import spi_burst_pkg::*;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 32;
    localparam int CLK_DIV = 2;
    localparam int NUM_CS  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_burst_tx_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CS(NUM_CS)) bus ();

    spi_burst_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV), .NUM_CS(NUM_CS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] model[$];
    bit                rx[$];
    int                busy_cyc, cs_cyc, done_cnt, first_lead;
    logic [NUM_CS-1:0] cs_seen;
    logic              prev_clk, m_cpol, mon_clr;

    // Wire monitor: records MOSI at every leading SPI clock edge and counts framing cycles.
    always @(negedge clk) begin
        if (mon_clr) begin
            rx.delete();
            busy_cyc   = 0;
            cs_cyc     = 0;
            done_cnt   = 0;
            first_lead = -1;
            cs_seen    = '0;
        end else begin
            if (bus.busy) busy_cyc++;
            if (bus.cs_n != {NUM_CS{1'b1}}) cs_cyc++;
            cs_seen = cs_seen | ~bus.cs_n;
            if (bus.done) done_cnt++;
            if (bus.busy && prev_clk == m_cpol && bus.spi_clk != m_cpol) begin
                rx.push_back(bus.spi_mosi);
                if (first_lead < 0) first_lead = busy_cyc;
            end
        end
        prev_clk = bus.spi_clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        bus.din       = w;
        bus.din_valid = 1'b1;
        cyc(1);
        bus.din_valid = 1'b0;
        model.push_back(w);
    endtask

    task automatic start_burst(input logic c, input int s);
        bus.cpol   = c;
        bus.cs_sel = s[1:0];
        cyc(2);
        mon_clr = 1'b1;
        m_cpol  = c;
        cyc(1);
        mon_clr   = 1'b0;
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
    endtask

    task automatic run_burst(input logic c, input int s, input bit poke);
        int n, k, win;
        logic [DATA_W-1:0] v;
        n   = model.size();
        win = CLK_DIV * (2 + 2 * n * DATA_W);
        start_burst(c, s);
        check("level_after_pop", 32'(bus.level), 32'(n - 1));
        check("ready_after_pop", 32'(bus.din_ready), 1);
        if (poke) begin
            cyc(8);
            bus.start  = 1'b1;
            bus.cpol   = ~c;
            bus.cs_sel = 2'((s + 1) % NUM_CS);
            cyc(1);
            bus.start  = 1'b0;
            bus.cpol   = c;
            bus.cs_sel = s[1:0];
        end
        k = 0;
        while (done_cnt == 0 && k < win + 100) begin
            cyc(1);
            k++;
        end
        check("done_in_time", 32'(done_cnt != 0), 1);
        cyc(3);
        check("done_pulses", 32'(done_cnt), 1);
        check("busy_cycles", 32'(busy_cyc), 32'(win));
        check("cs_low_cycles", 32'(cs_cyc), (s < NUM_CS) ? 32'(win) : 0);
        check("cs_lines", 32'(cs_seen), (s < NUM_CS) ? (32'd1 << s) : 0);
        check("first_lead", 32'(first_lead), 32'(CLK_DIV + 1));
        check("bit_count", 32'(rx.size()), 32'(n * DATA_W));
        for (int w = 0; w < n; w++) begin
            v = '0;
            for (int b = 0; b < DATA_W; b++)
                v = {v[DATA_W-2:0], (w * DATA_W + b < rx.size()) ? rx[w * DATA_W + b] : 1'b0};
            check("rx_word", 32'(v), 32'(model.pop_front()));
        end
        check("level_end", 32'(bus.level), 0);
        check("cs_released", 32'(bus.cs_n), 32'({NUM_CS{1'b1}}));
        check("idle_clk", 32'(bus.spi_clk), 32'(c));
    endtask

    initial begin
        int n, k;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.start     = 1'b0;
        bus.cs_sel    = '0;
        bus.cpol      = 1'b1;
        rst           = 1'b1;
        mon_clr       = 1'b1;
        m_cpol        = 1'b0;
        cyc(2);
        check("rst_cs_n", 32'(bus.cs_n), 32'({NUM_CS{1'b1}}));
        check("rst_spi_clk", 32'(bus.spi_clk), 0);
        check("rst_mosi", 32'(bus.spi_mosi), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_level", 32'(bus.level), 0);
        check("rst_ready", 32'(bus.din_ready), 0);
        rst = 1'b0;
        cyc(2);
        check("idle_follows_cpol", 32'(bus.spi_clk), 1);
        check("ready_after_rst", 32'(bus.din_ready), 1);
        bus.cpol = 1'b0;

        push_word(8'hA5);
        run_burst(1'b0, 0, 1'b0);

        push_word(8'h3C);
        push_word(8'hFF);
        push_word(8'h01);
        check("level_three", 32'(bus.level), 3);
        run_burst(1'b0, 1, 1'b0);

        push_word(8'h81);
        run_burst(1'b1, 2, 1'b0);

        push_word(8'h6E);
        push_word(8'h93);
        run_burst(1'b0, 3, 1'b0);

        push_word(8'hC4);
        run_burst(1'b1, 0, 1'b1);

        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) push_word(8'($urandom));
            run_burst(1'($urandom_range(0, 1)), $urandom_range(0, 3), it == 1);
        end

        for (int j = 0; j < DEPTH; j++) push_word(8'($urandom));
        check("full_level", 32'(bus.level), 32'(DEPTH));
        check("full_ready", 32'(bus.din_ready), 0);
        bus.din       = 8'h5A;
        bus.din_valid = 1'b1;
        cyc(3);
        check("held_write_level", 32'(bus.level), 32'(DEPTH));
        bus.din_valid = 1'b0;
        run_burst(1'b0, 1, 1'b0);

        start_burst(1'b0, 0);
        cyc(10);
        check("empty_start_busy", 32'(busy_cyc), 0);
        check("empty_start_done", 32'(done_cnt), 0);
        check("empty_start_cs", 32'(cs_cyc), 0);

        push_word(8'hB7);
        push_word(8'h42);
        start_burst(1'b0, 1);
        k = 0;
        while (rx.size() < 5 && k < 200) begin
            cyc(1);
            k++;
        end
        check("reached_bit4", 32'(rx.size() >= 5), 1);
        rst = 1'b1;
        cyc(1);
        check("mid_rst_cs_n", 32'(bus.cs_n), 32'({NUM_CS{1'b1}}));
        check("mid_rst_spi_clk", 32'(bus.spi_clk), 0);
        check("mid_rst_mosi", 32'(bus.spi_mosi), 0);
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_level", 32'(bus.level), 0);
        check("mid_rst_ready", 32'(bus.din_ready), 0);
        rst = 1'b0;
        model.delete();
        cyc(20);
        check("mid_rst_no_done", 32'(done_cnt), 0);
        check("mid_rst_idle_level", 32'(bus.level), 0);
        check("mid_rst_idle_busy", 32'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
